wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_entry_fifo.sv | 91 +++++++++
 rtl/wb_queue.sv | 161 ++++++++++++++++
 tb/tb_wb_queue.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared widths, default queue depth and the pending write-back
//            entry type used by the write-back queue and its storage.
// Contents : DATA_W, REG_W, DEPTH_DEFAULT, wb_entry_t {wa, wd}
// Revision : 1.0
// ============================================================================
package wb_pkg;

    localparam int DATA_W        = 32;
    localparam int REG_W         = 5;
    localparam int DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [REG_W-1:0]  wa;
        logic [DATA_W-1:0] wd;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_entry_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_entry_fifo
// Purpose  : Circular store of pending write-back entries. Accepts up to two
//            pushes per cycle (push0 lands before push1) and one pop, and
//            exposes every slot plus head/count for the hazard match logic.
// Ports    : clk, reset                - clock, synchronous active-high reset
//            push0_valid/push0_entry   - first (older) push of the cycle
//            push1_valid/push1_entry   - second push, only honoured with push0
//            pop                       - retire the head entry
//            entries[DEPTH]            - raw slot contents
//            head, count               - oldest slot index, occupancy
// Revision : 1.0
// ============================================================================
module wb_entry_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push0_valid,
    input  wb_entry_t        push0_entry,
    input  logic             push1_valid,
    input  wb_entry_t        push1_entry,
    input  logic             pop,
    output wb_entry_t        entries [DEPTH],
    output logic [PTR_W-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] tail_next;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push1_eff;
    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];

    always_comb begin
        mem_d     = mem_q;
        head_d    = head_q;
        tail_d    = tail_q;
        tail_next = tail_q + PTR_W'(1);
        // A second push only makes sense behind a first one; the caller
        // compacts a lone push onto port 0.
        push1_eff = push0_valid & push1_valid;

        if (push0_valid) begin
            mem_d[tail_q] = push0_entry;
            tail_d        = tail_next;
            if (push1_eff) begin
                mem_d[tail_next] = push1_entry;
                tail_d           = tail_next + PTR_W'(1);
            end
        end

        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end

        count_d = count_q + {{(CNT_W-1){1'b0}}, push0_valid}
                          + {{(CNT_W-1){1'b0}}, push1_eff}
                          - {{(CNT_W-1){1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Slot payloads need no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign entries = mem_q;
    assign head    = head_q;
    assign count   = count_q;

endmodule
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_queue
// Purpose  : Write-back queue between the load unit / ALU and a single
//            register-file write port. Buffers results, writes one per cycle
//            from the head, and flags/forwards pending values for ra1/ra2.
// Ports    : clk, reset                       - clock, sync active-high reset
//            ld_valid/ld_ready/ld_wa/ld_wd     - load-unit result handshake
//            alu_valid/alu_ready/alu_wa/alu_wd - ALU result handshake
//            we3/wa3/wd3                       - register-file write port
//            ra1/ra2                           - snooped read addresses
//            busy1/busy2                       - pending-write hazard flags
//            fwd1_*/fwd2_*                     - forwarded pending values
//            count                             - occupancy
// Macro    : WB_QUEUE_FWD_EN - enables the youngest-match forwarding data
//            path; otherwise fwd outputs are tied to zero.
// Revision : 1.0
// ============================================================================
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [REG_W-1:0]  ld_wa,
    input  logic [DATA_W-1:0] ld_wd,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_W-1:0]  alu_wa,
    input  logic [DATA_W-1:0] alu_wd,
    output logic              we3,
    output logic [REG_W-1:0]  wa3,
    output logic [DATA_W-1:0] wd3,
    input  logic [REG_W-1:0]  ra1,
    input  logic [REG_W-1:0]  ra2,
    output logic              busy1,
    output logic              busy2,
    output logic              fwd1_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd2_data,
    output logic [2:0]        count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] head;
    wb_entry_t        entries [DEPTH];
    wb_entry_t        head_entry;
    wb_entry_t        push0_entry, push1_entry;
    logic             push0_valid, push1_valid;
    logic             not_full, two_free;
    logic             ld_push, alu_push;

    // ---------------------------------------------------------------- handshake
    always_comb begin
        // Readiness looks only at current occupancy, never at the pop that
        // may happen on the same edge.
        not_full  = cnt < CNT_W'(DEPTH);
        two_free  = (CNT_W'(DEPTH) - cnt) >= CNT_W'(2);
        ld_ready  = !reset && not_full;
        alu_ready = !reset && (two_free || (not_full && !ld_valid));

        // Writes to register zero finish the handshake but are dropped.
        ld_push  = ld_valid  && ld_ready  && (ld_wa  != '0);
        alu_push = alu_valid && alu_ready && (alu_wa != '0);

        // Load goes first when both land; a lone ALU push uses port 0.
        push0_valid    = ld_push || alu_push;
        push1_valid    = ld_push && alu_push;
        push0_entry.wa = ld_push ? ld_wa : alu_wa;
        push0_entry.wd = ld_push ? ld_wd : alu_wd;
        push1_entry.wa = alu_wa;
        push1_entry.wd = alu_wd;
    end

    wb_entry_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push0_valid (push0_valid),
        .push0_entry (push0_entry),
        .push1_valid (push1_valid),
        .push1_entry (push1_entry),
        .pop         (we3),
        .entries     (entries),
        .head        (head),
        .count       (cnt)
    );

    // ------------------------------------------------------------ write port
    always_comb begin
        head_entry = entries[head];
        we3        = !reset && (cnt != '0);
        wa3        = we3 ? head_entry.wa : '0;
        wd3        = we3 ? head_entry.wd : '0;
    end

    assign count = 3'(cnt);

    // ------------------------------------------------------- hazard matching
    // Walk live slots oldest to youngest so a later match overrides an
    // earlier one, leaving the youngest value selected.
    logic [PTR_W-1:0] idx;
`ifdef WB_QUEUE_FWD_EN
    logic [DATA_W-1:0] match1_data, match2_data;
`endif

    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        idx   = '0;
`ifdef WB_QUEUE_FWD_EN
        match1_data = '0;
        match2_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (CNT_W'(k) < cnt) begin
                if (entries[idx].wa == ra1) begin
                    busy1 = 1'b1;
`ifdef WB_QUEUE_FWD_EN
                    match1_data = entries[idx].wd;
`endif
                end
                if (entries[idx].wa == ra2) begin
                    busy2 = 1'b1;
`ifdef WB_QUEUE_FWD_EN
                    match2_data = entries[idx].wd;
`endif
                end
            end
        end
        if (reset || ra1 == '0) begin
            busy1 = 1'b0;
        end
        if (reset || ra2 == '0) begin
            busy2 = 1'b0;
        end
    end

`ifdef WB_QUEUE_FWD_EN
    assign fwd1_hit  = busy1;
    assign fwd2_hit  = busy2;
    assign fwd1_data = busy1 ? match1_data : '0;
    assign fwd2_data = busy2 ? match2_data : '0;
`else
    assign fwd1_hit  = 1'b0;
    assign fwd2_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_data = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_queue
// Purpose  : Directed self-checking bench for wb_queue (DEPTH = 4).
// Revision : 1.0
// ============================================================================
module tb_wb_queue;

    logic        clk;
    logic        reset;
    logic        ld_valid, alu_valid;
    logic        ld_ready, alu_ready;
    logic [4:0]  ld_wa, alu_wa, ra1, ra2, wa3;
    logic [31:0] ld_wd, alu_wd, wd3;
    logic        we3, busy1, busy2, fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;
    int we_seen;

    wb_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_wa     (ld_wa),
        .ld_wd     (ld_wd),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_wa    (alu_wa),
        .alu_wd    (alu_wd),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .ra1       (ra1),
        .ra2       (ra2),
        .busy1     (busy1),
        .busy2     (busy2),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after it, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_valid  = 1'b0;
        alu_valid = 1'b0;
        ld_wa     = '0;
        ld_wd     = '0;
        alu_wa    = '0;
        alu_wd    = '0;
    endtask

    initial begin
        idle_inputs();
        ra1   = '0;
        ra2   = '0;
        reset = 1'b1;

        // ---------------------------------------------------------- reset
        tick();
        tick();
        ld_valid = 1'b1;
        alu_valid = 1'b1;
        alu_wa = 5'd7;
        #1;
        check_eq("rst_ld_ready",  ld_ready,  0);
        check_eq("rst_alu_ready", alu_ready, 0);
        check_eq("rst_we3",       we3,       0);
        idle_inputs();
        reset = 1'b0;
        #1;
        check_eq("init_count", count, 0);
        check_eq("init_we3",   we3,   0);
        check_eq("init_wa3",   wa3,   0);
        check_eq("init_wd3",   wd3,   0);
        check_eq("init_ld_ready",  ld_ready,  1);
        check_eq("init_alu_ready", alu_ready, 1);
        tick();

        // --------------------------------------------- single ALU push
        alu_valid = 1'b1;
        alu_wa    = 5'd3;
        alu_wd    = 32'h11;
        #1;
        check_eq("single_alu_ready", alu_ready, 1);
        tick();
        idle_inputs();
        ra1 = 5'd3;
        #1;
        check_eq("single_we3",   we3,   1);
        check_eq("single_wa3",   wa3,   3);
        check_eq("single_wd3",   wd3,   32'h11);
        check_eq("single_count", count, 1);
        check_eq("single_busy1", busy1, 1);
        tick();
        check_eq("single_count_after", count, 0);
        check_eq("single_we3_after",   we3,   0);
        check_eq("single_busy1_after", busy1, 0);

        // --------------------------------------------------- dual push
        ld_valid  = 1'b1; ld_wa  = 5'd5; ld_wd  = 32'hAA;
        alu_valid = 1'b1; alu_wa = 5'd5; alu_wd = 32'hBB;
        ra1 = 5'd5;
        #1;
        check_eq("dual_ld_ready",  ld_ready,  1);
        check_eq("dual_alu_ready", alu_ready, 1);
        check_eq("dual_no_snoop_incoming", busy1, 0);
        tick();
        idle_inputs();
        #1;
        check_eq("dual_count", count, 2);
        check_eq("dual_first_wa3", wa3, 5);
        check_eq("dual_first_wd3", wd3, 32'hAA);
        check_eq("dual_busy1", busy1, 1);
`ifdef WB_QUEUE_FWD_EN
        check_eq("dual_fwd_hit_pre",  fwd1_hit,  1);
        check_eq("dual_fwd_data_pre", fwd1_data, 32'hBB);
`else
        check_eq("dual_fwd_hit_off",  fwd1_hit,  0);
        check_eq("dual_fwd_data_off", fwd1_data, 0);
`endif
        tick();
        check_eq("dual_count_mid",  count, 1);
        check_eq("dual_second_wd3", wd3,   32'hBB);
        check_eq("dual_busy1_mid",  busy1, 1);
`ifdef WB_QUEUE_FWD_EN
        check_eq("dual_fwd_data_post", fwd1_data, 32'hBB);
`endif
        tick();
        check_eq("dual_count_end", count, 0);
        ra1 = '0;

        // ---------------------------------------------- full boundary
        ld_valid  = 1'b1; ld_wa  = 5'd1; ld_wd  = 32'h101;
        alu_valid = 1'b1; alu_wa = 5'd2; alu_wd = 32'h102;
        tick();
        ld_wa  = 5'd3; ld_wd  = 32'h103;
        alu_wa = 5'd4; alu_wd = 32'h104;
        #1;
        check_eq("fill_count2",     count,     2);
        check_eq("fill_alu_ready2", alu_ready, 1);
        tick();
        ld_wa  = 5'd6; ld_wd  = 32'h106;
        alu_wa = 5'd7; alu_wd = 32'h107;
        ra2 = 5'd4;
        #1;
        check_eq("full_count3",    count,     3);
        check_eq("full_ld_ready",  ld_ready,  1);
        check_eq("full_alu_ready", alu_ready, 0);
        check_eq("full_head_wa3",  wa3,       2);
        check_eq("full_busy2",     busy2,     1);
        tick();
        idle_inputs();
        alu_valid = 1'b1; alu_wa = 5'd7; alu_wd = 32'h107;
        #1;
        check_eq("full_count_after",    count,     3);
        check_eq("full_head_after",     wa3,       3);
        check_eq("full_alu_only_ready", alu_ready, 1);
        alu_valid = 1'b0;
        ra2 = 5'd7;
        #1;
        check_eq("full_busy2_dropped_alu", busy2, 0);
        ra2 = 5'd4;

        // --------------------------------------------- reset mid-flight
        reset = 1'b1;
        #1;
        check_eq("midrst_we3",      we3,      0);
        check_eq("midrst_ld_ready", ld_ready, 0);
        check_eq("midrst_busy2",    busy2,    0);
        tick();
        reset = 1'b0;
        #1;
        check_eq("midrst_count", count, 0);
        check_eq("midrst_we3_after", we3, 0);
        we_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (we3) we_seen++;
            tick();
        end
        check_eq("midrst_no_stale_writes", we_seen, 0);
        ra2 = '0;

        // ----------------------------------------------- register zero
        alu_valid = 1'b1; alu_wa = 5'd0; alu_wd = 32'hFF;
        ra1 = 5'd0;
        #1;
        check_eq("r0_alu_ready", alu_ready, 1);
        check_eq("r0_busy1",     busy1,     0);
        tick();
        idle_inputs();
        #1;
        check_eq("r0_count", count, 0);
        check_eq("r0_we3",   we3,   0);
        tick();
        check_eq("r0_we3_later", we3, 0);

        // --------------------------------------------------- wrap-around
        for (int i = 0; i < 10; i++) begin
            alu_valid = 1'b1;
            alu_wa    = 5'(i + 1);
            alu_wd    = 32'h1000 + 32'(i);
            tick();
            alu_valid = 1'b0;
            check_eq($sformatf("wrap_we3_%0d", i), we3, 1);
            check_eq($sformatf("wrap_wa3_%0d", i), wa3, 32'(i + 1));
            check_eq($sformatf("wrap_wd3_%0d", i), wd3, 32'h1000 + 32'(i));
            check_eq($sformatf("wrap_cnt_%0d", i), count, 1);
        end
        idle_inputs();
        tick();
        check_eq("wrap_count_end", count, 0);
        check_eq("wrap_we3_end",   we3,   0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
